// File: rtl/ecc_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ecc_result_buffer_pkg
// Purpose : Shared definitions for the PROM ECC result path. Defines word
//           widths, the packed FIFO entry layout and the status bit positions.
// Config  : ECC_RBUF_PARITY_EN - when defined, the parity word is carried in
//           every entry (26-bit entry). Otherwise the entry is 14 bits.
// Layout  : [ENTRY_W-1] = VALID, [ENTRY_W-2] = CORUPT, then data, then parity
//           (parity present only in the parity build).
// Revision: 1.0 - initial release
// ============================================================================
package ecc_result_buffer_pkg;

    localparam int c_ECC_DW = 12;
    localparam int c_ECC_PW = 12;

`ifdef ECC_RBUF_PARITY_EN
    localparam int c_ENTRY_W = 2 + c_ECC_DW + c_ECC_PW;
`else
    localparam int c_ENTRY_W = 2 + c_ECC_DW;
`endif

    localparam int c_ST_VALID_B  = c_ENTRY_W - 1;
    localparam int c_ST_CORUPT_B = c_ENTRY_W - 2;
    localparam int c_DATA_LSB    = c_ENTRY_W - 2 - c_ECC_DW;

endpackage : ecc_result_buffer_pkg
`default_nettype wire

// File: rtl/ecc_rbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ecc_rbuf_fifo
// Purpose : First-word-fall-through synchronous FIFO. Storage is a register
//           array with an asynchronous read of the head entry, so a word
//           written into an empty FIFO is visible right after its write edge.
// Ports   : clk, rst (sync, active-high)
//           wr, din      - write request / entry; accepted when not full or
//                          when a pop happens in the same cycle
//           rd           - pop request; ignored while empty
//           dout         - head entry (don't-care while empty)
//           full, empty  - occupancy flags
//           level        - occupancy, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module ecc_rbuf_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int             c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL_LVL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_level;

    logic w_pop;
    logic w_push;

    assign w_pop  = rd && (r_level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = wr && ((r_level != c_FULL_LVL) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed when level != 0.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign full  = (r_level == c_FULL_LVL);
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule : ecc_rbuf_fifo
`default_nettype wire

// File: rtl/ecc_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : ecc_result_buffer
// Purpose : Buffers strobed ECC decode results (data, optional parity and
//           VALID/CORUPT status) in a FWFT FIFO for the PROM readback
//           consumer, keeps saturating corrected / uncorrectable counts and a
//           sticky overflow flag for strobes dropped while full.
// Config  : ECC_RBUF_PARITY_EN - store PIN and present it on POUT; otherwise
//           PIN is ignored and POUT reads 12'h000.
// Ports   : CLK, RST (sync, active-high)
//           STB, DIN, PIN, VLD_IN, CORUPT_IN - decode result input
//           RD_EN     - consumer pop (effective only when DOUT_VLD)
//           CLR_CNT   - clears CORR_CNT, UNCOR_CNT and OVFL
//           DOUT, POUT, ST_VALID, ST_CORUPT - head entry
//           DOUT_VLD, FULL, LEVEL           - FIFO status
//           CORR_CNT, UNCOR_CNT, OVFL       - error statistics
// Revision: 1.0 - initial release
// ============================================================================
module ecc_result_buffer
    import ecc_result_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    STB,
    input  logic [11:0]             DIN,
    input  logic [11:0]             PIN,
    input  logic                    VLD_IN,
    input  logic                    CORUPT_IN,
    input  logic                    RD_EN,
    input  logic                    CLR_CNT,
    output logic [11:0]             DOUT,
    output logic [11:0]             POUT,
    output logic                    DOUT_VLD,
    output logic                    ST_VALID,
    output logic                    ST_CORUPT,
    output logic                    FULL,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic [CNT_W-1:0]        CORR_CNT,
    output logic [CNT_W-1:0]        UNCOR_CNT,
    output logic                    OVFL
);

    localparam int               c_AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_drop;
    logic [c_AW:0]        w_level;

    logic [CNT_W-1:0]     r_corr_cnt;
    logic [CNT_W-1:0]     r_uncor_cnt;
    logic                 r_ovfl;

`ifdef ECC_RBUF_PARITY_EN
    assign w_wr_entry = {VLD_IN, CORUPT_IN, DIN, PIN};
    assign POUT       = w_head[c_ECC_PW-1:0];
`else
    logic w_unused_pin;
    assign w_wr_entry   = {VLD_IN, CORUPT_IN, DIN};
    assign POUT         = 12'h000;
    assign w_unused_pin = ^PIN;
`endif

    ecc_rbuf_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .wr    (STB),
        .din   (w_wr_entry),
        .rd    (RD_EN),
        .dout  (w_head),
        .full  (FULL),
        .empty (w_empty),
        .level (w_level)
    );

    // Same-cycle pop makes room, so only a strobe into a full, non-draining
    // FIFO is lost.
    assign w_pop  = RD_EN && !w_empty;
    assign w_drop = STB && FULL && !w_pop;

    always_ff @(posedge CLK) begin
        if (RST || CLR_CNT) begin
            r_corr_cnt  <= '0;
            r_uncor_cnt <= '0;
            r_ovfl      <= 1'b0;
        end else begin
            // Counters see every strobe, including ones that get dropped.
            if (STB && VLD_IN && CORUPT_IN && (r_corr_cnt != c_CNT_MAX))
                r_corr_cnt <= r_corr_cnt + 1'b1;
            if (STB && !VLD_IN && (r_uncor_cnt != c_CNT_MAX))
                r_uncor_cnt <= r_uncor_cnt + 1'b1;
            if (w_drop)
                r_ovfl <= 1'b1;
        end
    end

    assign DOUT      = w_head[c_DATA_LSB +: c_ECC_DW];
    assign ST_VALID  = w_head[c_ST_VALID_B];
    assign ST_CORUPT = w_head[c_ST_CORUPT_B];
    assign DOUT_VLD  = !w_empty;
    assign LEVEL     = w_level;
    assign CORR_CNT  = r_corr_cnt;
    assign UNCOR_CNT = r_uncor_cnt;
    assign OVFL      = r_ovfl;

endmodule : ecc_result_buffer
`default_nettype wire

// File: tb/tb_ecc_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ecc_result_buffer
// Purpose : Self-checking bench for ecc_result_buffer (DEPTH=16, CNT_W=4).
//           Directed vector table, hand-written corner sequences and a
//           randomized run checked against a queue-based reference model.
// Config  : ECC_RBUF_PARITY_EN selects the expected POUT behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ecc_result_buffer;

    localparam int c_DEPTH = 16;
    localparam int c_CNT_W = 4;
    localparam int c_CMAX  = (1 << c_CNT_W) - 1;

    logic        CLK = 1'b0;
    logic        RST, STB, VLD_IN, CORUPT_IN, RD_EN, CLR_CNT;
    logic [11:0] DIN, PIN;
    logic [11:0] DOUT, POUT;
    logic        DOUT_VLD, ST_VALID, ST_CORUPT, FULL, OVFL;
    logic [4:0]  LEVEL;
    logic [c_CNT_W-1:0] CORR_CNT, UNCOR_CNT;

    ecc_result_buffer #(.DEPTH(c_DEPTH), .CNT_W(c_CNT_W)) dut (
        .CLK(CLK), .RST(RST), .STB(STB), .DIN(DIN), .PIN(PIN),
        .VLD_IN(VLD_IN), .CORUPT_IN(CORUPT_IN), .RD_EN(RD_EN),
        .CLR_CNT(CLR_CNT), .DOUT(DOUT), .POUT(POUT), .DOUT_VLD(DOUT_VLD),
        .ST_VALID(ST_VALID), .ST_CORUPT(ST_CORUPT), .FULL(FULL),
        .LEVEL(LEVEL), .CORR_CNT(CORR_CNT), .UNCOR_CNT(UNCOR_CNT), .OVFL(OVFL)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        logic [11:0] d;
        logic [11:0] p;
        logic        v;
        logic        c;
    } ent_t;

    ent_t m_q[$];
    int   m_corr, m_uncor;
    bit   m_ovfl;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_apply(input bit rst, stb, input logic [11:0] din, pin,
                               input bit vld, cor, rd, clr);
        bit pop, drop;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_corr = 0; m_uncor = 0; m_ovfl = 0;
            return;
        end
        pop  = rd && (m_q.size() > 0);
        drop = stb && (m_q.size() == c_DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (stb && !drop) begin
            e.d = din; e.p = pin; e.v = vld; e.c = cor;
            m_q.push_back(e);
        end
        if (clr) begin
            m_corr = 0; m_uncor = 0; m_ovfl = 0;
        end else begin
            if (stb && vld && cor) m_corr  = (m_corr  < c_CMAX) ? m_corr + 1  : c_CMAX;
            if (stb && !vld)       m_uncor = (m_uncor < c_CMAX) ? m_uncor + 1 : c_CMAX;
            if (drop) m_ovfl = 1;
        end
    endtask

    task automatic check_model();
        chk("level",     LEVEL,     m_q.size());
        chk("dout_vld",  DOUT_VLD,  m_q.size() != 0);
        chk("full",      FULL,      m_q.size() == c_DEPTH);
        chk("corr_cnt",  CORR_CNT,  m_corr);
        chk("uncor_cnt", UNCOR_CNT, m_uncor);
        chk("ovfl",      OVFL,      m_ovfl);
        if (m_q.size() != 0) begin
            chk("dout",      DOUT,      m_q[0].d);
            chk("st_valid",  ST_VALID,  m_q[0].v);
            chk("st_corupt", ST_CORUPT, m_q[0].c);
`ifdef ECC_RBUF_PARITY_EN
            chk("pout",      POUT,      m_q[0].p);
`else
            chk("pout",      POUT,      0);
`endif
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input bit rst, stb, input logic [11:0] din, pin,
                        input bit vld, cor, rd, clr);
        RST = rst; STB = stb; DIN = din; PIN = pin;
        VLD_IN = vld; CORUPT_IN = cor; RD_EN = rd; CLR_CNT = clr;
        model_apply(rst, stb, din, pin, vld, cor, rd, clr);
        @(posedge CLK);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 12'h000, 12'h000, 0, 0, 0, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          stb;
        logic [11:0] din;
        bit          vld, cor, rd, clr;
        bit          e_vld;
        int          e_level;
        logic [11:0] e_dout;
        int          e_corr, e_uncor;
    } vec_t;

    vec_t tbl[8];

    initial begin
        RST = 1; STB = 0; DIN = '0; PIN = '0; VLD_IN = 0; CORUPT_IN = 0;
        RD_EN = 0; CLR_CNT = 0;

        //         stb din     vld cor rd clr  e_vld lvl dout   corr uncor
        tbl[0] = '{1, 12'hA5C, 1, 0, 0, 0,    1,  1, 12'hA5C, 0, 0};
        tbl[1] = '{1, 12'h123, 1, 1, 0, 0,    1,  2, 12'hA5C, 1, 0};
        tbl[2] = '{1, 12'h456, 0, 1, 1, 0,    1,  2, 12'h123, 1, 1};
        tbl[3] = '{0, 12'h000, 0, 0, 1, 0,    1,  1, 12'h456, 1, 1};
        tbl[4] = '{0, 12'h000, 0, 0, 1, 0,    0,  0, 12'h000, 1, 1};
        tbl[5] = '{0, 12'h000, 0, 0, 1, 0,    0,  0, 12'h000, 1, 1};
        tbl[6] = '{1, 12'h7E7, 1, 1, 0, 1,    1,  1, 12'h7E7, 0, 0};
        tbl[7] = '{1, 12'h001, 0, 0, 1, 0,    1,  1, 12'h001, 0, 1};

        do_reset();
        do_reset();
        chk("rst_level", LEVEL, 0);
        chk("rst_vld",   DOUT_VLD, 0);
        chk("rst_full",  FULL, 0);
        chk("rst_ovfl",  OVFL, 0);

        for (int i = 0; i < 8; i++) begin
            step(0, tbl[i].stb, tbl[i].din, ~tbl[i].din, tbl[i].vld, tbl[i].cor,
                 tbl[i].rd, tbl[i].clr);
            chk($sformatf("tbl%0d_vld", i),   DOUT_VLD,  tbl[i].e_vld);
            chk($sformatf("tbl%0d_level", i), LEVEL,     tbl[i].e_level);
            chk($sformatf("tbl%0d_corr", i),  CORR_CNT,  tbl[i].e_corr);
            chk($sformatf("tbl%0d_uncor", i), UNCOR_CNT, tbl[i].e_uncor);
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_dout", i), DOUT, tbl[i].e_dout);
        end

        // ---- fill to full, then one dropped strobe ----
        do_reset();
        for (int i = 0; i < c_DEPTH; i++)
            step(0, 1, 12'(i * 3 + 1), 12'(i), 1, 0, 0, 0);
        step(0, 1, 12'hFFF, 12'hFFF, 1, 0, 0, 0);
        chk("ovf_full",  FULL,  1);
        chk("ovf_level", LEVEL, 16);
        chk("ovf_flag",  OVFL,  1);
        for (int i = 0; i < c_DEPTH; i++) begin
            chk($sformatf("ovf_order%0d", i), DOUT, i * 3 + 1);
            step(0, 0, 12'h000, 12'h000, 0, 0, 1, 0);
        end
        chk("ovf_drained", LEVEL, 0);
        chk("ovf_sticky",  OVFL,  1);

        // ---- reset mid-stream with 5 entries ----
        for (int i = 0; i < 5; i++)
            step(0, 1, 12'(i + 12'h100), 12'h000, 1, 0, 0, 0);
        chk("mid_level5", LEVEL, 5);
        do_reset();
        chk("mid_rst_level", LEVEL, 0);
        chk("mid_rst_vld",   DOUT_VLD, 0);
        chk("mid_rst_ovfl",  OVFL, 0);

        // ---- push + pop while full: no drop, new word last ----
        for (int i = 0; i < c_DEPTH; i++)
            step(0, 1, 12'(i + 12'h200), 12'h000, 1, 0, 0, 0);
        step(0, 1, 12'hABC, 12'h000, 1, 0, 1, 0);
        chk("pp_level", LEVEL, 16);
        chk("pp_ovfl",  OVFL,  0);
        chk("pp_head",  DOUT,  12'h201);
        for (int i = 0; i < c_DEPTH - 1; i++)
            step(0, 0, 12'h000, 12'h000, 0, 0, 1, 0);
        chk("pp_last_level", LEVEL, 1);
        chk("pp_last_dout",  DOUT,  12'hABC);

        // ---- counter classification ----
        step(0, 0, 12'h000, 12'h000, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 12'h0C0, 12'h000, 1, 1, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 12'h0E0, 12'h000, 0, 1, 1, 0);
        chk("cls_corr",  CORR_CNT,  3);
        chk("cls_uncor", UNCOR_CNT, 2);

        // ---- saturation and clear priority ----
        for (int i = 0; i < 20; i++) step(0, 1, 12'(i), 12'h000, 1, 1, 1, 0);
        chk("sat_corr", CORR_CNT, 15);
        step(0, 1, 12'h055, 12'h000, 1, 1, 1, 1);
        chk("clr_corr",  CORR_CNT,  0);
        chk("clr_uncor", UNCOR_CNT, 0);

        // ---- parity path ----
        do_reset();
        step(0, 1, 12'h111, 12'h3C3, 1, 0, 0, 0);
`ifdef ECC_RBUF_PARITY_EN
        chk("pout_par", POUT, 12'h3C3);
`else
        chk("pout_tied", POUT, 12'h000);
`endif

        // ---- randomized run against the model ----
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int rd_pct;
            rd_pct = ((i / 100) % 2 == 0) ? 20 : 75;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 70,
                 12'($urandom), 12'($urandom),
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 99) < rd_pct,
                 $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ecc_result_buffer
`default_nettype wire
